// File: rtl/d_branch_pkg.sv
// Shared definitions for the D-stage branch unit: compare-op encodings,
// predictor counter constants and the saturating counter update rule.
package d_branch_pkg;

    typedef enum logic [2:0] {
        OP_BEQ    = 3'b000,
        OP_BNE    = 3'b001,
        OP_BLEZ   = 3'b010,
        OP_BGTZ   = 3'b011,
        OP_BLTZ   = 3'b100,
        OP_BGEZ   = 3'b101,
        OP_NONE_A = 3'b110,
        OP_NONE_B = 3'b111
    } cmp_op_e;

    // Weakly not-taken: first taken outcome flips the prediction.
    localparam logic [1:0] CTR_RESET = 2'b01;
    localparam logic [1:0] CTR_MAX   = 2'b11;
    localparam logic [1:0] CTR_MIN   = 2'b00;

    // Next value of a 2-bit saturating counter given the resolved outcome.
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            if (ctr == CTR_MAX) begin
                nxt = ctr;
            end else begin
                nxt = ctr + 2'd1;
            end
        end else begin
            if (ctr == CTR_MIN) begin
                nxt = ctr;
            end else begin
                nxt = ctr - 2'd1;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/d_bht.sv
// Branch history table: DEPTH 2-bit saturating counters with one
// combinational read port and one synchronous saturating-update write port.
// Reset forces every counter to the weakly-not-taken value asynchronously,
// which also discards any update that would have landed on the next edge.
module d_bht
    import d_branch_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_ctr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    logic [1:0] ctr_r [DEPTH];

    // Counter storage: async clear to weakly-not-taken, saturating update on write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr_r[i] <= CTR_RESET;
            end
        end else if (wr_en) begin
            ctr_r[wr_idx] <= ctr_next(ctr_r[wr_idx], wr_taken);
        end
    end

    // Read port returns the stored value; a same-cycle write is not bypassed.
    always_comb begin
        rd_ctr = ctr_r[rd_idx];
    end

endmodule

// File: rtl/d_branch_unit.sv
// D-stage branch resolution with a bimodal predictor for the F stage.
// Optional statistics counters are enabled by defining BRANCH_STATS_EN.
module d_branch_unit
    import d_branch_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int BHT_DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d_valid,
    input  logic             d_stall,
    input  logic [2:0]       d_cmp_op,
    input  logic [WIDTH-1:0] d_rdata1,
    input  logic [WIDTH-1:0] d_rdata2,
    input  logic [31:0]      d_pc,
    input  logic             d_pred_taken,
    input  logic [31:0]      f_pc,
    output logic             d_taken,
    output logic             d_mispredict,
    output logic             f_pred_taken
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]      stat_branches,
    output logic [31:0]      stat_mispredicts
`endif
);

    localparam int IDX_W = (BHT_DEPTH > 1) ? $clog2(BHT_DEPTH) : 1;

    logic             is_branch_s;
    logic             cond_s;
    logic             op_neg_s;
    logic             op_zero_s;
    logic             update_s;
    logic [1:0]       rd_ctr_s;
    logic [IDX_W-1:0] f_idx_s;
    logic [IDX_W-1:0] d_idx_s;
    logic             unused_pc_bits_s;

    assign f_idx_s = f_pc[IDX_W+1:2];
    assign d_idx_s = d_pc[IDX_W+1:2];
    assign unused_pc_bits_s = ^{f_pc[31:IDX_W+2], f_pc[1:0], d_pc[31:IDX_W+2], d_pc[1:0]};

    // Zero-compare helpers: two's-complement sign and all-zero test of rdata1.
    always_comb begin
        op_neg_s  = d_rdata1[WIDTH-1];
        op_zero_s = (d_rdata1 == {WIDTH{1'b0}});
    end

    // Decode the compare op into the branch condition and branch/non-branch class.
    always_comb begin
        cond_s      = 1'b0;
        is_branch_s = 1'b1;
        case (d_cmp_op)
            OP_BEQ:  cond_s = (d_rdata1 == d_rdata2);
            OP_BNE:  cond_s = (d_rdata1 != d_rdata2);
            OP_BLEZ: cond_s = op_neg_s | op_zero_s;
            OP_BGTZ: cond_s = ~op_neg_s & ~op_zero_s;
            OP_BLTZ: cond_s = op_neg_s;
            OP_BGEZ: cond_s = ~op_neg_s;
            default: begin
                cond_s      = 1'b0;
                is_branch_s = 1'b0;
            end
        endcase
    end

    // Resolution, misprediction and the single per-instruction update strobe.
    always_comb begin
        d_taken      = d_valid & cond_s;
        d_mispredict = d_valid & is_branch_s & (d_taken != d_pred_taken);
        update_s     = d_valid & ~d_stall & is_branch_s;
    end

    d_bht #(
        .DEPTH (BHT_DEPTH),
        .IDX_W (IDX_W)
    ) u_bht (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (f_idx_s),
        .rd_ctr   (rd_ctr_s),
        .wr_en    (update_s),
        .wr_idx   (d_idx_s),
        .wr_taken (d_taken)
    );

    // F-stage prediction: counter MSB, held not-taken while in reset.
    always_comb begin
        if (!reset) begin
            f_pred_taken = 1'b0;
        end else begin
            f_pred_taken = rd_ctr_s[1];
        end
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches_r;
    logic [31:0] stat_mispredicts_r;

    // Saturating counts of resolved branches and of mispredicted ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_branches_r    <= 32'd0;
            stat_mispredicts_r <= 32'd0;
        end else if (update_s) begin
            if (stat_branches_r != 32'hFFFF_FFFF) begin
                stat_branches_r <= stat_branches_r + 32'd1;
            end
            if (d_mispredict && (stat_mispredicts_r != 32'hFFFF_FFFF)) begin
                stat_mispredicts_r <= stat_mispredicts_r + 32'd1;
            end
        end
    end

    assign stat_branches    = stat_branches_r;
    assign stat_mispredicts = stat_mispredicts_r;
`endif

endmodule

// File: tb/tb_d_branch_unit.sv
// Self-checking bench for d_branch_unit: directed scenarios plus a randomized
// run compared against a behavioural predictor model.
module tb_d_branch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        d_valid = 1'b0;
    logic        d_stall = 1'b0;
    logic [2:0]  d_cmp_op = 3'b111;
    logic [31:0] d_rdata1 = 32'd0;
    logic [31:0] d_rdata2 = 32'd0;
    logic [31:0] d_pc = 32'd0;
    logic        d_pred_taken = 1'b0;
    logic [31:0] f_pc = 32'd0;
    logic        d_taken;
    logic        d_mispredict;
    logic        f_pred_taken;
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    int total = 0;
    int bad = 0;

    // Model state: one counter per table entry, values 0..3.
    int model_ctr [16];
    longint model_br = 0;
    longint model_mp = 0;

    d_branch_unit #(.WIDTH(32), .BHT_DEPTH(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .d_valid      (d_valid),
        .d_stall      (d_stall),
        .d_cmp_op     (d_cmp_op),
        .d_rdata1     (d_rdata1),
        .d_rdata2     (d_rdata2),
        .d_pc         (d_pc),
        .d_pred_taken (d_pred_taken),
        .f_pc         (f_pc),
        .d_taken      (d_taken),
        .d_mispredict (d_mispredict),
        .f_pred_taken (f_pred_taken)
`ifdef BRANCH_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    function automatic bit ref_is_branch(input logic [2:0] op);
        return op <= 3'd5;
    endfunction

    function automatic bit ref_cond(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        sa = longint'($signed(a));
        case (op)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd2: return sa <= 0;
            3'd3: return sa > 0;
            3'd4: return sa < 0;
            3'd5: return sa >= 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit exp_taken();
        return d_valid && ref_cond(d_cmp_op, d_rdata1, d_rdata2);
    endfunction

    function automatic bit exp_mispredict();
        return d_valid && ref_is_branch(d_cmp_op) && (exp_taken() != d_pred_taken);
    endfunction

    function automatic bit exp_pred();
        if (reset !== 1'b1) return 1'b0;
        return model_ctr[f_pc[5:2]] >= 2;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) model_ctr[i] = 1;
        model_br = 0;
        model_mp = 0;
    endtask

    // Advance one clock, applying the update rule to the model.
    task automatic tick();
        bit upd;
        bit tk;
        bit mp;
        int idx;
        upd = (reset === 1'b1) && d_valid && !d_stall && ref_is_branch(d_cmp_op);
        tk  = exp_taken();
        mp  = exp_mispredict();
        idx = int'(d_pc[5:2]);
        @(posedge clk);
        if (upd) begin
            if (tk) model_ctr[idx] = (model_ctr[idx] == 3) ? 3 : model_ctr[idx] + 1;
            else    model_ctr[idx] = (model_ctr[idx] == 0) ? 0 : model_ctr[idx] - 1;
            model_br++;
            if (mp) model_mp++;
        end
        #1;
    endtask

    task automatic drive(input bit v, input bit s, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] dpc, input bit pred, input logic [31:0] fpc);
        d_valid = v; d_stall = s; d_cmp_op = op; d_rdata1 = a; d_rdata2 = b;
        d_pc = dpc; d_pred_taken = pred; f_pc = fpc;
    endtask

    task automatic do_reset();
        #2 reset = 1'b0;
        model_clear();
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 3'b111, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
        model_clear();
        #3;
        for (int i = 0; i < 4; i++) begin
            f_pc = 32'h3000 + 32'(i * 4);
            #1;
            total++;
            if (f_pred_taken !== 1'b0) begin
                bad++; $display("FAIL reset_pred f_pc=%h got=%b exp=0", f_pc, f_pred_taken);
            end
        end
        @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            f_pc = 32'(i * 4);
            #1;
            total++;
            if (f_pred_taken !== 1'b0) begin
                bad++; $display("FAIL post_reset_pred idx=%0d got=%b exp=0", i, f_pred_taken);
            end
        end
`ifdef BRANCH_STATS_EN
        total++;
        if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin
            bad++; $display("FAIL reset_stats got=%0d/%0d exp=0/0", stat_branches, stat_mispredicts);
        end
`endif
    endtask

    task automatic test_directed_compare();
        logic [31:0] vals [4];
        logic [2:0]  ops  [4];
        bit          exps [4];
        ops[0] = 3'd0; vals[0] = 32'h1234;      exps[0] = 1'b1;
        ops[1] = 3'd2; vals[1] = 32'h8000_0000; exps[1] = 1'b1;
        ops[2] = 3'd3; vals[2] = 32'h0;         exps[2] = 1'b0;
        ops[3] = 3'd5; vals[3] = 32'h0;         exps[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, ops[i], vals[i], (i == 0) ? 32'h1234 : 32'hDEAD_BEEF, 32'h100, 1'b0, 32'h100);
            #2;
            total++;
            if (d_taken !== exps[i]) begin
                bad++; $display("FAIL directed_taken case=%0d got=%b exp=%b", i, d_taken, exps[i]);
            end
            total++;
            if (d_mispredict !== exps[i]) begin
                bad++; $display("FAIL directed_mispredict case=%0d got=%b exp=%b", i, d_mispredict, exps[i]);
            end
            tick();
        end
        // NONE codes and invalid instruction never resolve taken.
        drive(1'b1, 1'b0, 3'd6, 32'h0, 32'h0, 32'h100, 1'b1, 32'h100);
        #2;
        total++;
        if (d_taken !== 1'b0 || d_mispredict !== 1'b0) begin
            bad++; $display("FAIL none_op got=%b%b exp=00", d_taken, d_mispredict);
        end
        tick();
        drive(1'b0, 1'b0, 3'd0, 32'h5, 32'h5, 32'h100, 1'b0, 32'h100);
        #2;
        total++;
        if (d_taken !== 1'b0 || d_mispredict !== 1'b0) begin
            bad++; $display("FAIL invalid_gate got=%b%b exp=00", d_taken, d_mispredict);
        end
        tick();
    endtask

    function automatic logic [31:0] pick_val(input logic [31:0] other);
        case ($urandom_range(0, 4))
            0: return 32'd0;
            1: return other;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        logic [31:0] a;
        for (int n = 0; n < 400; n++) begin
            a = pick_val(32'h55);
            drive(($urandom_range(0, 9) != 0), ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
                  a, pick_val(a), {$urandom_range(0, 3) == 0 ? 32'h0 : $urandom} & 32'hFFFF_FF3F | 32'($urandom_range(0, 3) << 2),
                  1'($urandom_range(0, 1)), $urandom);
            #2;
            total++;
            if (d_taken !== exp_taken()) begin
                bad++; $display("FAIL rand_taken n=%0d op=%0d a=%h b=%h got=%b exp=%b", n, d_cmp_op, d_rdata1, d_rdata2, d_taken, exp_taken());
            end
            total++;
            if (d_mispredict !== exp_mispredict()) begin
                bad++; $display("FAIL rand_mispredict n=%0d got=%b exp=%b", n, d_mispredict, exp_mispredict());
            end
            total++;
            if (f_pred_taken !== exp_pred()) begin
                bad++; $display("FAIL rand_pred n=%0d f_pc=%h got=%b exp=%b", n, f_pc, f_pred_taken, exp_pred());
            end
`ifdef BRANCH_STATS_EN
            total++;
            if (stat_branches !== 32'(model_br) || stat_mispredicts !== 32'(model_mp)) begin
                bad++; $display("FAIL rand_stats n=%0d got=%0d/%0d exp=%0d/%0d", n, stat_branches, stat_mispredicts, model_br, model_mp);
            end
`endif
            tick();
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int n = 0; n < 4; n++) begin
            drive(1'b1, 1'b0, 3'd0, 32'h9, 32'h9, 32'h3000, 1'b1, 32'h3000);
            tick();
            #1;
            total++;
            if (f_pred_taken !== exp_pred()) begin
                bad++; $display("FAIL sat_train n=%0d got=%b exp=%b", n, f_pred_taken, exp_pred());
            end
        end
        total++;
        if (f_pred_taken !== 1'b1) begin
            bad++; $display("FAIL sat_top got=%b exp=1", f_pred_taken);
        end
        // Two not-taken steps: 11 -> 10 (still taken) -> 01 (not taken).
        for (int n = 0; n < 2; n++) begin
            drive(1'b1, 1'b0, 3'd1, 32'h9, 32'h9, 32'h3000, 1'b0, 32'h3000);
            tick();
            #1;
            total++;
            if (f_pred_taken !== ((n == 0) ? 1'b1 : 1'b0)) begin
                bad++; $display("FAIL sat_untrain n=%0d got=%b exp=%b", n, f_pred_taken, (n == 0));
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        drive(1'b1, 1'b1, 3'd1, 32'h1, 32'h2, 32'h3008, 1'b0, 32'h3008);
        for (int n = 0; n < 5; n++) begin
            tick();
            total++;
            if (f_pred_taken !== 1'b0) begin
                bad++; $display("FAIL stall_hold n=%0d got=%b exp=0", n, f_pred_taken);
            end
        end
        d_stall = 1'b0;
        tick();
        d_valid = 1'b0;
        tick();
        total++;
        if (f_pred_taken !== 1'b1) begin
            bad++; $display("FAIL stall_release got=%b exp=1", f_pred_taken);
        end
        // One not-taken: only a single prior increment returns to not-taken.
        drive(1'b1, 1'b0, 3'd0, 32'h1, 32'h2, 32'h3008, 1'b1, 32'h3008);
        tick();
        total++;
        if (f_pred_taken !== 1'b0) begin
            bad++; $display("FAIL stall_single_inc got=%b exp=0", f_pred_taken);
        end
    endtask

    task automatic test_same_index();
        do_reset();
        drive(1'b1, 1'b0, 3'd5, 32'h4, 32'h0, 32'h3004, 1'b0, 32'h3004);
        #2;
        total++;
        if (f_pred_taken !== 1'b0) begin
            bad++; $display("FAIL same_idx_pre got=%b exp=0", f_pred_taken);
        end
        tick();
        d_valid = 1'b0;
        #1;
        total++;
        if (f_pred_taken !== 1'b1) begin
            bad++; $display("FAIL same_idx_post got=%b exp=1", f_pred_taken);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        for (int n = 0; n < 6; n++) begin
            drive(1'b1, 1'b0, 3'd0, 32'h7, 32'h7, (n < 3) ? 32'h3000 : 32'h3010, 1'b0, 32'h3000);
            tick();
        end
        // Pending taken update at 0x3000 when reset strikes mid-cycle.
        drive(1'b1, 1'b0, 3'd0, 32'h7, 32'h7, 32'h3000, 1'b0, 32'h3000);
        #2 reset = 1'b0;
        model_clear();
        #1;
        total++;
        if (f_pred_taken !== 1'b0) begin
            bad++; $display("FAIL mid_reset_pred got=%b exp=0", f_pred_taken);
        end
        total++;
        if (d_taken !== 1'b1 || d_mispredict !== 1'b1) begin
            bad++; $display("FAIL mid_reset_comb got=%b%b exp=11", d_taken, d_mispredict);
        end
`ifdef BRANCH_STATS_EN
        total++;
        if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin
            bad++; $display("FAIL mid_reset_stats got=%0d/%0d exp=0/0", stat_branches, stat_mispredicts);
        end
`endif
        tick();
        reset = 1'b1;
        d_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            f_pc = 32'(i * 4);
            #1;
            total++;
            if (f_pred_taken !== 1'b0) begin
                bad++; $display("FAIL mid_reset_table idx=%0d got=%b exp=0", i, f_pred_taken);
            end
        end
        // From 01 a single taken update must flip the prediction.
        drive(1'b1, 1'b0, 3'd0, 32'h7, 32'h7, 32'h3000, 1'b1, 32'h3000);
        tick();
        total++;
        if (f_pred_taken !== 1'b1) begin
            bad++; $display("FAIL mid_reset_first_update got=%b exp=1", f_pred_taken);
        end
    endtask

    initial begin
        test_reset();
        test_directed_compare();
        test_random();
        test_saturate();
        test_stall();
        test_same_index();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/d_branch_unit.md
D_BRANCH_UNIT -- requirements
Module: d_branch_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width in bits.
REQ-002 SHALL have parameter BHT_DEPTH, default 16: number of predictor entries; power of two, 2..256.
REQ-003 SHALL have clk, input, 1: sole clock; all state updates on the rising edge.
REQ-004 SHALL have reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have d_valid, input, 1: D-stage instruction valid.
REQ-006 SHALL have d_stall, input, 1: D stage stalled this cycle.
REQ-007 SHALL have d_cmp_op, input, 3: compare mode.
REQ-008 SHALL have d_rdata1 and d_rdata2, input, WIDTH each: forwarded operands.
REQ-009 SHALL have d_pc, input, 32: D-stage PC.
REQ-010 SHALL have d_pred_taken, input, 1: prediction made in F and carried in the F/D register.
REQ-011 SHALL have f_pc, input, 32: F-stage PC used for lookup.
REQ-012 SHALL have d_taken, output, 1: branch resolution.
REQ-013 SHALL have d_mispredict, output, 1: resolution differs from prediction.
REQ-014 SHALL have f_pred_taken, output, 1: prediction for f_pc.

Function
REQ-015 SHALL decode d_cmp_op as follows: 000 BEQ (rdata1==rdata2); 001 BNE (!=); 010 BLEZ (signed rdata1<=0); 011 BGTZ (>0); 100 BLTZ (<0); 101 BGEZ (>=0).
REQ-016 SHALL treat codes 110 and 111 as NONE, giving d_taken=0, not counting the instruction as a branch, and leaving the table unchanged.
REQ-017 SHALL compute d_taken combinationally from the current-cycle inputs with zero latency, gated by d_valid.
REQ-018 SHALL interpret all signed compares as two's complement over WIDTH bits, with rdata2 ignored for the zero-compare modes.
REQ-019 SHALL drive d_mispredict = d_valid & is_branch & (d_taken != d_pred_taken), combinationally.
REQ-020 SHALL hold BHT_DEPTH 2-bit saturating counters, indexed by pc[log2(BHT_DEPTH)+1:2].
REQ-021 SHALL drive f_pred_taken from bit 1 of the counter indexed by f_pc, read combinationally.
REQ-022 SHALL define an update event as d_valid & !d_stall & is_branch, so each D instruction updates at most once.
REQ-023 SHALL, on an update event at the next rising edge, increment the counter indexed by d_pc when taken, saturating at 11.
REQ-024 SHALL, on an update event, decrement the counter indexed by d_pc when not taken, saturating at 00.
REQ-025 SHALL, when F lookup and D update hit the same index in one cycle, return the pre-update value on f_pred_taken (no bypass).
REQ-026 SHALL make no state change while d_stall=1 or d_valid=0.

Reset
REQ-027 SHALL, on reset assertion, set every counter to 01 (weakly not-taken) immediately, independent of clk.
REQ-028 SHALL, while reset is asserted, drive f_pred_taken to 0.
REQ-029 SHALL leave d_taken and d_mispredict as pure functions of their inputs during reset.
REQ-030 SHALL, when reset asserts mid-operation, discard any pending update.
REQ-031 SHALL allow the first update on the first rising edge after deassertion.

Configuration
REQ-032 SHALL, when macro BRANCH_STATS_EN is defined, add outputs stat_branches and stat_mispredicts, 32 bits each.
REQ-033 SHALL increment stat_branches on each update event and stat_mispredicts on each update event with d_mispredict=1.
REQ-034 SHALL saturate both statistics counters at 32'hFFFF_FFFF and reset them to 0.
REQ-035 SHALL, when BRANCH_STATS_EN is not defined, omit those ports and registers entirely, with function otherwise identical.

Structure
REQ-036 SHALL place the op encodings (BEQ..NONE), the counter reset value 01 and the saturation limits in shared package d_branch_pkg.
REQ-037 SHALL implement the counter table as sub-module d_bht, providing one combinational read port and one synchronous write port with saturating update; comparator and mispredict logic stay in the top module.

Verification
REQ-038 SHALL cover: BEQ with rdata1=rdata2=32'h1234, d_pred_taken=0, d_valid=1 -> d_taken=1, d_mispredict=1.
REQ-039 SHALL cover: BLEZ with rdata1=32'h8000_0000 -> d_taken=1; BGTZ with rdata1=0 -> d_taken=0; BGEZ with rdata1=0 -> d_taken=1.
REQ-040 SHALL cover: after reset, 3 taken updates at d_pc=32'h3000 -> counter 11 and f_pred_taken=1 at f_pc=32'h3000; a 4th taken update leaves it at 11.
REQ-041 SHALL cover: d_stall=1 for 5 cycles with a taken BNE -> counter unchanged; then d_stall=0 for one cycle -> exactly one increment.
REQ-042 SHALL cover: f_pc=d_pc=32'h3004 with an update from 01 to 10 -> f_pred_taken=0 that cycle and 1 the next.
REQ-043 SHALL cover: reset asserted between clock edges after training -> all counters 01 immediately; with BRANCH_STATS_EN, both statistics counters read 0.
